// File: rtl/fp_norm_pkg.sv
// Shared definitions for the FP adder result normalizer: state encoding,
// default widths and the saturated (all-ones) exponent value.
package fp_norm_pkg;

    localparam int MW_DEF = 16;
    localparam int EW_DEF = 8;

    localparam logic [EW_DEF-1:0] EXP_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_NORM = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/fp_result_normalizer_round.sv
// fp_round_incr: combinational round-up of the shifted mantissa; no state, no handshake.
// Kogge-Stone KPG prefix adder with b tied to zero and the round bit as carry-in.
module fp_round_incr #(
    parameter int W = 16
) (
    input  logic [W-1:0] t_i,
    input  logic         rnd_i,
    output logic [W-1:0] sum_o,
    output logic         carry_o
);

    localparam int LV = $clog2(W);

    logic [W-1:0] b_zero;
    logic [W-1:0] p0;
    logic [W-1:0] gl;
    logic [W-1:0] pl;
    logic [W-1:0] gn;
    logic [W-1:0] pn;
    logic [W:0]   c;

    assign b_zero = '0;

    always_comb begin
        p0 = t_i ^ b_zero;
        gl = t_i & b_zero;
        pl = p0;
        gn = gl;
        pn = pl;
        for (int l = 0; l < LV; l++) begin
            gn = gl;
            pn = pl;
            for (int i = (1 << l); i < W; i++) begin
                gn[i] = gl[i] | (pl[i] & gl[i - (1 << l)]);
                pn[i] = pl[i] & pl[i - (1 << l)];
            end
            gl = gn;
            pl = pn;
        end
        // Group terms span [i:0]; fold in the carry-in as a bit -1 generate.
        c[0] = rnd_i;
        for (int i = 0; i < W; i++) begin
            c[i+1] = gl[i] | (pl[i] & rnd_i);
        end
        sum_o   = p0 ^ c[W-1:0];
        carry_o = c[W];
    end

endmodule

// File: rtl/fp_result_normalizer.sv
// Normalizes/rounds the raw FP adder sum: 1-step right shift on carry, 1 bit/cycle left shift.
// Latency 2+n edges from accept; result held in DONE until out_ready, in_ready only in IDLE.
module fp_result_normalizer
    import fp_norm_pkg::*;
#(
    parameter int MW = MW_DEF,
    parameter int EW = EW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [MW:0]   sum_in,
    input  logic [EW-1:0] exp_in,
    input  logic          sign_in,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [MW-1:0] mant_out,
    output logic [EW-1:0] exp_out,
    output logic          sign_out,
    output logic          zero_out,
    output logic          ovf_out,
    output logic          denorm_out
);

    localparam logic [EW-1:0] E_MAX = '1;

    state_t        state_q, state_d;
    logic [MW:0]   m_q, m_d;
    logic [EW-1:0] e_q, e_d;
    logic          s_q, s_d;
    logic [MW-1:0] mant_q, mant_d;
    logic [EW-1:0] exp_q, exp_d;
    logic          sign_q, sign_d;
    logic          zero_q, zero_d;
    logic          ovf_q, ovf_d;
    logic          denorm_q, denorm_d;

    logic [MW-1:0] t;
    logic          rnd;
    logic [MW-1:0] t_rnd;
    logic          rnd_cy;
    logic [EW:0]   e_up;

    // Only one bit drops on the right shift, so sticky is zero: round up on guard && lsb.
    assign t   = m_q[MW:1];
    assign rnd = m_q[0] & m_q[1];

    fp_round_incr #(.W(MW)) u_round (
        .t_i     (t),
        .rnd_i   (rnd),
        .sum_o   (t_rnd),
        .carry_o (rnd_cy)
    );

    always_comb begin
        state_d  = state_q;
        m_d      = m_q;
        e_d      = e_q;
        s_d      = s_q;
        mant_d   = mant_q;
        exp_d    = exp_q;
        sign_d   = sign_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        denorm_d = denorm_q;
        e_up     = {1'b0, e_q} + (EW+1)'(1) + (EW+1)'(rnd_cy);

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    m_d     = sum_in;
                    e_d     = exp_in;
                    s_d     = sign_in;
                    state_d = ST_NORM;
                end
            end
            ST_NORM: begin
                sign_d   = s_q;
                zero_d   = 1'b0;
                ovf_d    = 1'b0;
                denorm_d = 1'b0;
                mant_d   = m_q[MW-1:0];
                exp_d    = e_q;
                state_d  = ST_DONE;
                if (e_q == E_MAX) begin
                    // inf/NaN already resolved upstream: pass through
                end else if (m_q == '0) begin
                    zero_d = 1'b1;
                    exp_d  = '0;
                    mant_d = '0;
                end else if (m_q[MW]) begin
                    if (e_up >= {1'b0, E_MAX}) begin
                        ovf_d  = 1'b1;
                        exp_d  = E_MAX;
                        mant_d = '0;
                    end else begin
                        exp_d  = e_up[EW-1:0];
                        mant_d = rnd_cy ? {1'b1, {(MW-1){1'b0}}} : t_rnd;
                    end
                end else if (m_q[MW-1]) begin
                    // already normalized
                end else if (e_q == '0) begin
                    denorm_d = 1'b1;
                end else begin
                    m_d     = {m_q[MW-1:0], 1'b0};
                    e_d     = e_q - EW'(1);
                    state_d = ST_NORM;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            m_q      <= '0;
            e_q      <= '0;
            s_q      <= 1'b0;
            mant_q   <= '0;
            exp_q    <= '0;
            sign_q   <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            denorm_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            m_q      <= m_d;
            e_q      <= e_d;
            s_q      <= s_d;
            mant_q   <= mant_d;
            exp_q    <= exp_d;
            sign_q   <= sign_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            denorm_q <= denorm_d;
        end
    end

    assign in_ready   = (state_q == ST_IDLE);
    assign out_valid  = (state_q == ST_DONE);
    assign mant_out   = mant_q;
    assign exp_out    = exp_q;
    assign sign_out   = sign_q;
    assign zero_out   = zero_q;
    assign ovf_out    = ovf_q;
    assign denorm_out = denorm_q;

endmodule

// File: tb/tb_fp_result_normalizer.sv
// Directed table-driven bench for fp_result_normalizer plus back-pressure and reset sequences.
module tb_fp_result_normalizer;

    localparam int MW = 16;
    localparam int EW = 8;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [MW:0]   sum_in;
    logic [EW-1:0] exp_in;
    logic          sign_in;
    logic          out_valid;
    logic          out_ready;
    logic [MW-1:0] mant_out;
    logic [EW-1:0] exp_out;
    logic          sign_out;
    logic          zero_out;
    logic          ovf_out;
    logic          denorm_out;

    fp_result_normalizer #(.MW(MW), .EW(EW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .sum_in     (sum_in),
        .exp_in     (exp_in),
        .sign_in    (sign_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .mant_out   (mant_out),
        .exp_out    (exp_out),
        .sign_out   (sign_out),
        .zero_out   (zero_out),
        .ovf_out    (ovf_out),
        .denorm_out (denorm_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [MW:0]   sum;
        logic [EW-1:0] ex;
        logic          sg;
        logic [MW-1:0] x_mant;
        logic [EW-1:0] x_exp;
        logic          x_zero;
        logic          x_ovf;
        logic          x_den;
        int            x_lat;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // Offer one operand, count edges (accept edge = 1) until out_valid, check result, then handshake.
    task automatic run_op(input vec_t v, input string tag);
        int edges;
        @(negedge clk);
        chk({tag, " in_ready before"}, 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        sum_in    = v.sum;
        exp_in    = v.ex;
        sign_in   = v.sg;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        edges = 1;
        while (!out_valid && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
        end
        chk({tag, " latency"}, 32'(edges), 32'(v.x_lat));
        chk({tag, " out_valid"}, 32'(out_valid), 32'd1);
        chk({tag, " mant"}, 32'(mant_out), 32'(v.x_mant));
        chk({tag, " exp"}, 32'(exp_out), 32'(v.x_exp));
        chk({tag, " sign"}, 32'(sign_out), 32'(v.sg));
        chk({tag, " flags"}, {29'd0, zero_out, ovf_out, denorm_out},
            {29'd0, v.x_zero, v.x_ovf, v.x_den});
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, " out_valid drop"}, 32'(out_valid), 32'd0);
        chk({tag, " in_ready back"}, 32'(in_ready), 32'd1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, " mant"}, 32'(mant_out), 32'd0);
        chk({tag, " exp"}, 32'(exp_out), 32'd0);
        chk({tag, " sign/flags"}, {28'd0, sign_out, zero_out, ovf_out, denorm_out}, 32'd0);
    endtask

    initial begin
        vec_t v;
        //             sum        exp    sg   mant      exp    z     o     d    lat
        vecs[0]  = '{17'h1_8001, 8'd10,  1'b0, 16'hC000, 8'd11,  1'b0, 1'b0, 1'b0, 2};
        vecs[1]  = '{17'h1_FFFF, 8'd10,  1'b1, 16'h8000, 8'd12,  1'b0, 1'b0, 1'b0, 2};
        vecs[2]  = '{17'h0_0010, 8'd20,  1'b0, 16'h8000, 8'd9,   1'b0, 1'b0, 1'b0, 13};
        vecs[3]  = '{17'h0_0000, 8'd5,   1'b1, 16'h0000, 8'd0,   1'b1, 1'b0, 1'b0, 2};
        vecs[4]  = '{17'h0_0001, 8'd3,   1'b0, 16'h0008, 8'd0,   1'b0, 1'b0, 1'b1, 5};
        vecs[5]  = '{17'h1_0000, 8'd254, 1'b0, 16'h0000, 8'hFF,  1'b0, 1'b1, 1'b0, 2};
        vecs[6]  = '{17'h0_8123, 8'd50,  1'b1, 16'h8123, 8'd50,  1'b0, 1'b0, 1'b0, 2};
        vecs[7]  = '{17'h0_0001, 8'd255, 1'b0, 16'h0001, 8'hFF,  1'b0, 1'b0, 1'b0, 2};
        vecs[8]  = '{17'h1_0003, 8'd100, 1'b0, 16'h8002, 8'd101, 1'b0, 1'b0, 1'b0, 2};
        vecs[9]  = '{17'h0_4000, 8'd0,   1'b0, 16'h4000, 8'd0,   1'b0, 1'b0, 1'b1, 2};
        vecs[10] = '{17'h1_FFFF, 8'd253, 1'b1, 16'h0000, 8'hFF,  1'b0, 1'b1, 1'b0, 2};
        vecs[11] = '{17'h0_0001, 8'd20,  1'b0, 16'h8000, 8'd5,   1'b0, 1'b0, 1'b0, 17};
        vecs[12] = '{17'h0_7FFF, 8'd10,  1'b0, 16'hFFFE, 8'd9,   1'b0, 1'b0, 1'b0, 3};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        sum_in    = '0;
        exp_in    = '0;
        sign_in   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk_all_zero("reset");

        for (int i = 0; i < NV; i++) begin
            run_op(vecs[i], $sformatf("vec%0d", i));
        end

        // Back-pressure: result and handshake state must hold while out_ready is low.
        @(negedge clk);
        in_valid = 1'b1;
        sum_in   = 17'h1_8001;
        exp_in   = 8'd10;
        sign_in  = 1'b1;
        @(posedge clk);
        #1;
        sum_in = 17'h0_0010;
        exp_in = 8'd40;
        begin
            int n;
            n = 1;
            while (!out_valid && n < 40) begin
                @(posedge clk);
                #1;
                n++;
            end
            chk("bp latency", 32'(n), 32'd2);
        end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("bp%0d out_valid", c), 32'(out_valid), 32'd1);
            chk($sformatf("bp%0d in_ready", c), 32'(in_ready), 32'd0);
            chk($sformatf("bp%0d mant", c), 32'(mant_out), 32'hC000);
            chk($sformatf("bp%0d exp", c), 32'(exp_out), 32'd11);
            chk($sformatf("bp%0d sign", c), 32'(sign_out), 32'd1);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp release out_valid", 32'(out_valid), 32'd0);
        chk("bp release in_ready", 32'(in_ready), 32'd1);

        // Reset in the middle of a long left-normalization must abort with no output.
        @(negedge clk);
        in_valid = 1'b1;
        sum_in   = 17'h0_0010;
        exp_in   = 8'd20;
        sign_in  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("mid-norm busy", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        chk_all_zero("in reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) begin
            @(posedge clk);
            #1;
            chk("post-reset no output", 32'(out_valid), 32'd0);
        end
        chk_all_zero("after reset");

        v = vecs[0];
        run_op(v, "post-reset op");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
